window_buffer_9x9: RTL and testbench

WINDOW_BUFFER_9X9 -- requirements
Module: window_buffer_9x9

---
 rtl/window_buffer_9x9.sv | 115 +++++++++++
 tb/tb_window_buffer_9x9.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_9x9.sv
// 9x9 sliding pixel window fed one 9-pixel column per accepted beat.
// Flags a window valid only once nine beats of the current line have been shifted in.
module window_buffer_9x9 #(
    parameter int unsigned COLS = 11,
    parameter int unsigned ROWS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done_i,
    input  logic [7:0] S1_i, S2_i, S3_i, S4_i, S5_i, S6_i, S7_i, S8_i, S9_i,
    output logic [7:0] S1_o,  S2_o,  S3_o,  S4_o,  S5_o,  S6_o,  S7_o,  S8_o,  S9_o,
    output logic [7:0] S10_o, S11_o, S12_o, S13_o, S14_o, S15_o, S16_o, S17_o, S18_o,
    output logic [7:0] S19_o, S20_o, S21_o, S22_o, S23_o, S24_o, S25_o, S26_o, S27_o,
    output logic [7:0] S28_o, S29_o, S30_o, S31_o, S32_o, S33_o, S34_o, S35_o, S36_o,
    output logic [7:0] S37_o, S38_o, S39_o, S40_o, S41_o, S42_o, S43_o, S44_o, S45_o,
    output logic [7:0] S46_o, S47_o, S48_o, S49_o, S50_o, S51_o, S52_o, S53_o, S54_o,
    output logic [7:0] S55_o, S56_o, S57_o, S58_o, S59_o, S60_o, S61_o, S62_o, S63_o,
    output logic [7:0] S64_o, S65_o, S66_o, S67_o, S68_o, S69_o, S70_o, S71_o, S72_o,
    output logic [7:0] S73_o, S74_o, S75_o, S76_o, S77_o, S78_o, S79_o, S80_o, S81_o,
    output logic       done_o,
    output logic       progress_done_o
);
    localparam int unsigned N  = 9;
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned LW = $clog2(ROWS - 7);

    logic [7:0]    col_in [N];
    logic [7:0]    win    [N][N];
    logic [CW-1:0] col;
    logic [LW-1:0] line;
    logic          last_col;
    logic          last_line;

    assign col_in[0] = S1_i;
    assign col_in[1] = S2_i;
    assign col_in[2] = S3_i;
    assign col_in[3] = S4_i;
    assign col_in[4] = S5_i;
    assign col_in[5] = S6_i;
    assign col_in[6] = S7_i;
    assign col_in[7] = S8_i;
    assign col_in[8] = S9_i;

    assign last_col  = (col == CW'(COLS - 1));
    assign last_line = (line == LW'(ROWS - 9));

    // Window shift register: column 0 is oldest, column 8 receives the new column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    win[r][c] <= 8'h00;
                end
            end
        end else if (done_i) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][N-1] <= col_in[r];
            end
        end
    end

    // Beat position within the frame and the window-valid / end-of-frame flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col             <= '0;
            line            <= '0;
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
        end else if (done_i) begin
            done_o          <= (col >= CW'(8));
            progress_done_o <= last_col && last_line;
            if (last_col) begin
                col  <= '0;
                line <= last_line ? '0 : line + LW'(1);
            end else begin
                col  <= col + CW'(1);
            end
        end else begin
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
        end
    end

    assign S1_o  = win[0][0]; assign S2_o  = win[0][1]; assign S3_o  = win[0][2];
    assign S4_o  = win[0][3]; assign S5_o  = win[0][4]; assign S6_o  = win[0][5];
    assign S7_o  = win[0][6]; assign S8_o  = win[0][7]; assign S9_o  = win[0][8];
    assign S10_o = win[1][0]; assign S11_o = win[1][1]; assign S12_o = win[1][2];
    assign S13_o = win[1][3]; assign S14_o = win[1][4]; assign S15_o = win[1][5];
    assign S16_o = win[1][6]; assign S17_o = win[1][7]; assign S18_o = win[1][8];
    assign S19_o = win[2][0]; assign S20_o = win[2][1]; assign S21_o = win[2][2];
    assign S22_o = win[2][3]; assign S23_o = win[2][4]; assign S24_o = win[2][5];
    assign S25_o = win[2][6]; assign S26_o = win[2][7]; assign S27_o = win[2][8];
    assign S28_o = win[3][0]; assign S29_o = win[3][1]; assign S30_o = win[3][2];
    assign S31_o = win[3][3]; assign S32_o = win[3][4]; assign S33_o = win[3][5];
    assign S34_o = win[3][6]; assign S35_o = win[3][7]; assign S36_o = win[3][8];
    assign S37_o = win[4][0]; assign S38_o = win[4][1]; assign S39_o = win[4][2];
    assign S40_o = win[4][3]; assign S41_o = win[4][4]; assign S42_o = win[4][5];
    assign S43_o = win[4][6]; assign S44_o = win[4][7]; assign S45_o = win[4][8];
    assign S46_o = win[5][0]; assign S47_o = win[5][1]; assign S48_o = win[5][2];
    assign S49_o = win[5][3]; assign S50_o = win[5][4]; assign S51_o = win[5][5];
    assign S52_o = win[5][6]; assign S53_o = win[5][7]; assign S54_o = win[5][8];
    assign S55_o = win[6][0]; assign S56_o = win[6][1]; assign S57_o = win[6][2];
    assign S58_o = win[6][3]; assign S59_o = win[6][4]; assign S60_o = win[6][5];
    assign S61_o = win[6][6]; assign S62_o = win[6][7]; assign S63_o = win[6][8];
    assign S64_o = win[7][0]; assign S65_o = win[7][1]; assign S66_o = win[7][2];
    assign S67_o = win[7][3]; assign S68_o = win[7][4]; assign S69_o = win[7][5];
    assign S70_o = win[7][6]; assign S71_o = win[7][7]; assign S72_o = win[7][8];
    assign S73_o = win[8][0]; assign S74_o = win[8][1]; assign S75_o = win[8][2];
    assign S76_o = win[8][3]; assign S77_o = win[8][4]; assign S78_o = win[8][5];
    assign S79_o = win[8][6]; assign S80_o = win[8][7]; assign S81_o = win[8][8];

endmodule

// File: tb/tb_window_buffer_9x9.sv
// Directed bench for window_buffer_9x9 at COLS=ROWS=11: vector table for fill, stalls
// and frame end, plus hand sequences for row mapping and asynchronous reset mid-line.
module tb_window_buffer_9x9;

    typedef struct {
        logic       dv;     // done_i for this cycle
        logic [7:0] px;     // value driven on every Sr_i
        logic       ed;     // expected done_o
        logic       ep;     // expected progress_done_o
        logic [7:0] enew;   // expected column 9, every row
        logic [7:0] eleft;  // expected column 1 of a ramp window (column c = eleft + c - 1)
        logic       full;   // check the whole ramp window
    } vec_t;

    logic       clk;
    logic       rst;
    logic       done_i;
    logic [7:0] si [9];
    logic [7:0] o  [81];
    logic       done_o;
    logic       progress_done_o;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    window_buffer_9x9 #(.COLS(11), .ROWS(11)) dut (
        .clk(clk), .rst(rst), .done_i(done_i),
        .S1_i(si[0]), .S2_i(si[1]), .S3_i(si[2]), .S4_i(si[3]), .S5_i(si[4]),
        .S6_i(si[5]), .S7_i(si[6]), .S8_i(si[7]), .S9_i(si[8]),
        .S1_o(o[0]),   .S2_o(o[1]),   .S3_o(o[2]),   .S4_o(o[3]),   .S5_o(o[4]),   .S6_o(o[5]),   .S7_o(o[6]),   .S8_o(o[7]),   .S9_o(o[8]),
        .S10_o(o[9]),  .S11_o(o[10]), .S12_o(o[11]), .S13_o(o[12]), .S14_o(o[13]), .S15_o(o[14]), .S16_o(o[15]), .S17_o(o[16]), .S18_o(o[17]),
        .S19_o(o[18]), .S20_o(o[19]), .S21_o(o[20]), .S22_o(o[21]), .S23_o(o[22]), .S24_o(o[23]), .S25_o(o[24]), .S26_o(o[25]), .S27_o(o[26]),
        .S28_o(o[27]), .S29_o(o[28]), .S30_o(o[29]), .S31_o(o[30]), .S32_o(o[31]), .S33_o(o[32]), .S34_o(o[33]), .S35_o(o[34]), .S36_o(o[35]),
        .S37_o(o[36]), .S38_o(o[37]), .S39_o(o[38]), .S40_o(o[39]), .S41_o(o[40]), .S42_o(o[41]), .S43_o(o[42]), .S44_o(o[43]), .S45_o(o[44]),
        .S46_o(o[45]), .S47_o(o[46]), .S48_o(o[47]), .S49_o(o[48]), .S50_o(o[49]), .S51_o(o[50]), .S52_o(o[51]), .S53_o(o[52]), .S54_o(o[53]),
        .S55_o(o[54]), .S56_o(o[55]), .S57_o(o[56]), .S58_o(o[57]), .S59_o(o[58]), .S60_o(o[59]), .S61_o(o[60]), .S62_o(o[61]), .S63_o(o[62]),
        .S64_o(o[63]), .S65_o(o[64]), .S66_o(o[65]), .S67_o(o[66]), .S68_o(o[67]), .S69_o(o[68]), .S70_o(o[69]), .S71_o(o[70]), .S72_o(o[71]),
        .S73_o(o[72]), .S74_o(o[73]), .S75_o(o[74]), .S76_o(o[75]), .S77_o(o[76]), .S78_o(o[77]), .S79_o(o[78]), .S80_o(o[79]), .S81_o(o[80]),
        .done_o(done_o), .progress_done_o(progress_done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_bit(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0b want=%0b", nm, got, want);
        end
    endtask

    task automatic check_zero(input string nm);
        int bad_idx = -1;
        checks++;
        for (int k = 0; k < 81; k++) if (bad_idx < 0 && o[k] !== 8'h00) bad_idx = k;
        if (bad_idx >= 0) begin
            failures++;
            $display("FAIL %s S%0d_o got=%h want=00", nm, bad_idx + 1, o[bad_idx]);
        end
    endtask

    task automatic check_vec(input string nm, input logic ed, input logic ep,
                             input logic [7:0] enew, input logic [7:0] eleft, input logic full);
        int bad_idx;
        logic [7:0] want;
        check_bit({nm, " done_o"}, done_o, ed);
        check_bit({nm, " progress_done_o"}, progress_done_o, ep);
        bad_idx = -1;
        checks++;
        for (int r = 0; r < 9; r++) if (bad_idx < 0 && o[9*r+8] !== enew) bad_idx = 9*r + 8;
        if (bad_idx >= 0) begin
            failures++;
            $display("FAIL %s newest S%0d_o got=%h want=%h", nm, bad_idx + 1, o[bad_idx], enew);
        end
        if (full) begin
            bad_idx = -1;
            want = 8'h00;
            checks++;
            for (int r = 0; r < 9; r++)
                for (int c = 0; c < 9; c++)
                    if (bad_idx < 0 && o[9*r+c] !== eleft + 8'(c)) begin
                        bad_idx = 9*r + c;
                        want = eleft + 8'(c);
                    end
            if (bad_idx >= 0) begin
                failures++;
                $display("FAIL %s window S%0d_o got=%h want=%h", nm, bad_idx + 1, o[bad_idx], want);
            end
        end
    endtask

    // One clock: drive done_i/pixels now, sample 1 time unit after the rising edge.
    task automatic cycle(input logic dv, input logic [7:0] px);
        done_i = dv;
        for (int r = 0; r < 9; r++) si[r] = px;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        done_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #4;
    endtask

    task automatic add_beat(input int i);
        logic ed;
        ed = (i inside {9, 10, 11, 20, 21, 22, 31, 32, 33, 42});
        vecs.push_back('{1'b1, 8'(i), ed, (i == 33), 8'(i), 8'(i - 8), (i >= 9)});
    endtask

    task automatic add_gap(input int last, input int n);
        for (int k = 0; k < n; k++)
            vecs.push_back('{1'b0, 8'hEE, 1'b0, 1'b0, 8'(last), 8'(last - 8), (last >= 9)});
    endtask

    initial begin
        rst    = 1'b1;
        done_i = 1'b0;
        for (int r = 0; r < 9; r++) si[r] = 8'h00;

        // Table: two lines of fill, a third line ending the frame, then a new frame.
        for (int i = 1; i <= 42; i++) begin
            add_beat(i);
            if (i == 10) add_gap(10, 1);
            if (i == 27) add_gap(27, 5);
            if (i == 33) add_gap(33, 1);
        end

        #3;
        rst = 1'b0;
        #1;
        check_zero("reset async");
        @(posedge clk);
        #1;
        check_zero("reset held");
        check_bit("reset done_o", done_o, 1'b0);
        check_bit("reset progress_done_o", progress_done_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #4;

        foreach (vecs[i]) begin
            cycle(vecs[i].dv, vecs[i].px);
            check_vec($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ep,
                      vecs[i].enew, vecs[i].eleft, vecs[i].full);
        end

        // Row mapping: Sr_i = 16*r + beat, so S(9*(r-1)+c)_o = 16*r + c after beat 9.
        do_reset();
        for (int b = 1; b <= 9; b++) begin
            done_i = 1'b1;
            for (int r = 0; r < 9; r++) si[r] = 8'(16 * (r + 1) + b);
            @(posedge clk);
            #1;
        end
        check_bit("rowmap done_o", done_o, 1'b1);
        begin
            int bad_idx = -1;
            logic [7:0] want = 8'h00;
            checks++;
            for (int r = 0; r < 9; r++)
                for (int c = 0; c < 9; c++)
                    if (bad_idx < 0 && o[9*r+c] !== 8'(16 * (r + 1) + c + 1)) begin
                        bad_idx = 9*r + c;
                        want = 8'(16 * (r + 1) + c + 1);
                    end
            if (bad_idx >= 0) begin
                failures++;
                $display("FAIL rowmap S%0d_o got=%h want=%h", bad_idx + 1, o[bad_idx], want);
            end
        end

        // Asynchronous reset between edges after beat 6 of a line, then a fresh line.
        do_reset();
        for (int b = 1; b <= 6; b++) cycle(1'b1, 8'(8'h40 + b));
        check_vec("pre-rst beat6", 1'b0, 1'b0, 8'h46, 8'h00, 1'b0);
        done_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_zero("midline rst outputs");
        check_bit("midline rst done_o", done_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #4;
        for (int b = 1; b <= 9; b++) begin
            cycle(1'b1, 8'(b));
            check_vec($sformatf("post-rst beat%0d", b), (b == 9), 1'b0, 8'(b), 8'h01, (b == 9));
        end
        cycle(1'b0, 8'h00);
        check_bit("post-rst idle done_o", done_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
